axi_ddr_sim_model: RTL and testbench

- Behavioural AXI3-style DDR slave model with a single shared read/write address channel (AW/AR merged, selected by `atype_0`).
- Connects to the SoC `io_ddrA_*` port and serves one burst at a time from an internal 128-bit-wide memory array.
- Used by SoC-level simulations, such as DMA S2MM/MM2S traffic, in place of the real DDR controller.
- Models function only, not performance.

---
 rtl/axi_ddr_sim_pkg.sv | 39 +++
 rtl/axi_ddr_sim_mem.sv | 30 +++
 rtl/axi_ddr_sim_model.sv | 171 +++++++++++++++++
 tb/tb_axi_ddr_sim_model.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_ddr_sim_pkg.sv
// Shared types and constants for the AXI DDR behavioural model.
package axi_ddr_sim_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StWait,
      StWdata,
      StBresp,
      StRdata
   } state_e;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   // Next word address of a burst; WRAP with an illegal length degrades to INCR.
   function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                             input logic [7:0]  len,
                                             input logic [1:0]  burst);
      logic [31:0] inc;
      logic [31:0] mask;
      inc  = addr + 32'd1;
      mask = {24'd0, len};
      case (burst)
         BURST_FIXED: next_addr = addr;
         BURST_WRAP: begin
            if (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15) begin
               next_addr = (addr & ~mask) | (inc & mask);
            end else begin
               next_addr = inc;
            end
         end
         default: next_addr = inc;
      endcase
   endfunction

endpackage

// File: rtl/axi_ddr_sim_mem.sv
// Byte-enable write, asynchronous read memory array of 2^MEM_ADDR_WIDTH wide words.
module axi_ddr_sim_mem #(
   parameter int unsigned MEM_ADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH     = 128,
   localparam int unsigned STRB_WIDTH    = DATA_WIDTH / 8
) (
   input  logic                      clk_i,
   input  logic                      we_i,
   input  logic [MEM_ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0]     wdata_i,
   input  logic [STRB_WIDTH-1:0]     wstrb_i,
   output logic [DATA_WIDTH-1:0]     rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [0:(1 << MEM_ADDR_WIDTH)-1];

   // Write only the strobed bytes of the addressed word.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int b = 0; b < int'(STRB_WIDTH); b++) begin
            if (wstrb_i[b]) begin
               mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
         end
      end
   end

   assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/axi_ddr_sim_model.sv
// Behavioural AXI3-style DDR slave with a merged AW/AR channel, one burst at a time.
// Optional macro SIM_DDR_LATENCY_EN inserts LATENCY wait cycles before the first data beat.
module axi_ddr_sim_model
   import axi_ddr_sim_pkg::*;
#(
   parameter int unsigned MEM_ADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH     = 128,
   parameter int unsigned LATENCY        = 4,
   localparam int unsigned STRB_WIDTH    = DATA_WIDTH / 8
) (
   input  logic                  mem_clk,
   input  logic                  resetn,
   input  logic [7:0]            aid_0,
   input  logic [31:0]           aaddr_0,
   input  logic [7:0]            alen_0,
   input  logic [2:0]            asize_0,
   input  logic [1:0]            aburst_0,
   input  logic [1:0]            alock_0,
   input  logic                  avalid_0,
   output logic                  aready_0,
   input  logic                  atype_0,
   input  logic [7:0]            wid_0,
   input  logic [DATA_WIDTH-1:0] wdata_0,
   input  logic [STRB_WIDTH-1:0] wstrb_0,
   input  logic                  wlast_0,
   input  logic                  wvalid_0,
   output logic                  wready_0,
   output logic [7:0]            rid_0,
   output logic [DATA_WIDTH-1:0] rdata_0,
   output logic [1:0]            rresp_0,
   output logic                  rlast_0,
   output logic                  rvalid_0,
   input  logic                  rready_0,
   output logic [7:0]            bid_0,
   output logic                  bvalid_0,
   input  logic                  bready_0
);

   state_e                    state_q, state_d;
   logic [7:0]                id_q, id_d;
   logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]                len_q, len_d;
   logic [1:0]                burst_q, burst_d;
   logic [7:0]                cnt_q, cnt_d;
   logic [31:0]               step_addr;
   logic                      mem_we;
   logic [DATA_WIDTH-1:0]     mem_rdata;
`ifdef SIM_DDR_LATENCY_EN
   logic [31:0]               wait_q, wait_d;
   logic                      wr_q, wr_d;
`else
   localparam int unsigned unused_latency = LATENCY;
`endif

   // Size, lock, write ID and sub-word address bits carry no meaning for this model.
   logic unused_inputs;
   assign unused_inputs = ^{asize_0, alock_0, wid_0, aaddr_0};

   // Next-state, burst bookkeeping and memory write enable.
   always_comb begin
      state_d   = state_q;
      id_d      = id_q;
      addr_d    = addr_q;
      len_d     = len_q;
      burst_d   = burst_q;
      cnt_d     = cnt_q;
      mem_we    = 1'b0;
      step_addr = next_addr(32'(addr_q), len_q, burst_q);
`ifdef SIM_DDR_LATENCY_EN
      wait_d    = wait_q;
      wr_d      = wr_q;
`endif
      case (state_q)
         StIdle: begin
            if (avalid_0) begin
               id_d    = aid_0;
               addr_d  = aaddr_0[MEM_ADDR_WIDTH+3:4];
               len_d   = alen_0;
               burst_d = aburst_0;
               cnt_d   = 8'd0;
`ifdef SIM_DDR_LATENCY_EN
               wait_d  = 32'd0;
               wr_d    = atype_0;
               if (LATENCY != 0) state_d = StWait;
               else              state_d = atype_0 ? StWdata : StRdata;
`else
               state_d = atype_0 ? StWdata : StRdata;
`endif
            end
         end
`ifdef SIM_DDR_LATENCY_EN
         StWait: begin
            if (wait_q == LATENCY - 1) state_d = wr_q ? StWdata : StRdata;
            else                       wait_d  = wait_q + 32'd1;
         end
`endif
         StWdata: begin
            if (wvalid_0) begin
               mem_we = 1'b1;
               addr_d = step_addr[MEM_ADDR_WIDTH-1:0];
               cnt_d  = cnt_q + 8'd1;
               if (wlast_0 || cnt_q == len_q) state_d = StBresp;
            end
         end
         StBresp: begin
            if (bready_0) state_d = StIdle;
         end
         StRdata: begin
            if (rready_0) begin
               addr_d = step_addr[MEM_ADDR_WIDTH-1:0];
               cnt_d  = cnt_q + 8'd1;
               if (cnt_q == len_q) state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and burst registers; reset aborts any burst in flight.
   always_ff @(posedge mem_clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= StIdle;
         id_q    <= 8'd0;
         addr_q  <= '0;
         len_q   <= 8'd0;
         burst_q <= BURST_INCR;
         cnt_q   <= 8'd0;
`ifdef SIM_DDR_LATENCY_EN
         wait_q  <= 32'd0;
         wr_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         burst_q <= burst_d;
         cnt_q   <= cnt_d;
`ifdef SIM_DDR_LATENCY_EN
         wait_q  <= wait_d;
         wr_q    <= wr_d;
`endif
      end
   end

   axi_ddr_sim_mem #(
      .MEM_ADDR_WIDTH(MEM_ADDR_WIDTH),
      .DATA_WIDTH    (DATA_WIDTH)
   ) u_mem (
      .clk_i  (mem_clk),
      .we_i   (mem_we),
      .addr_i (addr_q),
      .wdata_i(wdata_0),
      .wstrb_i(wstrb_0),
      .rdata_o(mem_rdata)
   );

   // Handshake outputs decode straight from the state register.
   always_comb begin
      aready_0 = (state_q == StIdle);
      wready_0 = (state_q == StWdata);
      bvalid_0 = (state_q == StBresp);
      rvalid_0 = (state_q == StRdata);
      rlast_0  = rvalid_0 && (cnt_q == len_q);
      rdata_0  = rvalid_0 ? mem_rdata : '0;
      rid_0    = id_q;
      bid_0    = id_q;
      rresp_0  = RESP_OKAY;
   end

endmodule

// File: tb/tb_axi_ddr_sim_model.sv
// Scoreboard bench for axi_ddr_sim_model: expected read beats are queued at command time.
module tb_axi_ddr_sim_model;

   logic         mem_clk = 1'b0;
   logic         resetn  = 1'b0;
   logic [7:0]   aid_0 = '0;
   logic [31:0]  aaddr_0 = '0;
   logic [7:0]   alen_0 = '0;
   logic [2:0]   asize_0 = 3'd4;
   logic [1:0]   aburst_0 = 2'b01;
   logic [1:0]   alock_0 = '0;
   logic         avalid_0 = 1'b0;
   logic         aready_0;
   logic         atype_0 = 1'b0;
   logic [7:0]   wid_0 = '0;
   logic [127:0] wdata_0 = '0;
   logic [15:0]  wstrb_0 = '0;
   logic         wlast_0 = 1'b0;
   logic         wvalid_0 = 1'b0;
   logic         wready_0;
   logic [7:0]   rid_0;
   logic [127:0] rdata_0;
   logic [1:0]   rresp_0;
   logic         rlast_0;
   logic         rvalid_0;
   logic         rready_0 = 1'b0;
   logic [7:0]   bid_0;
   logic         bvalid_0;
   logic         bready_0 = 1'b0;

   int total = 0;
   int bad   = 0;
   logic [127:0] exp_q [$];
   logic [127:0] wbuf [16];

   localparam logic [127:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;

   axi_ddr_sim_model dut (
      .mem_clk (mem_clk),  .resetn  (resetn),
      .aid_0   (aid_0),    .aaddr_0 (aaddr_0), .alen_0  (alen_0),  .asize_0 (asize_0),
      .aburst_0(aburst_0), .alock_0 (alock_0), .avalid_0(avalid_0), .aready_0(aready_0),
      .atype_0 (atype_0),  .wid_0   (wid_0),   .wdata_0 (wdata_0), .wstrb_0 (wstrb_0),
      .wlast_0 (wlast_0),  .wvalid_0(wvalid_0), .wready_0(wready_0),
      .rid_0   (rid_0),    .rdata_0 (rdata_0), .rresp_0 (rresp_0), .rlast_0 (rlast_0),
      .rvalid_0(rvalid_0), .rready_0(rready_0),
      .bid_0   (bid_0),    .bvalid_0(bvalid_0), .bready_0(bready_0)
   );

   always #5 mem_clk = ~mem_clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   // Present a command at a negedge and hold it until accepted.
   task automatic send_cmd(input logic wr, input logic [7:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
      int n = 0;
      aid_0 = id; aaddr_0 = addr; alen_0 = len; aburst_0 = burst; atype_0 = wr;
      avalid_0 = 1'b1;
      while (aready_0 !== 1'b1 && n < 50) begin @(negedge mem_clk); n++; end
      total++;
      if (aready_0 !== 1'b1) begin
         bad++; $display("FAIL cmd_accept got=%b exp=1", aready_0);
      end
      @(negedge mem_clk);
      avalid_0 = 1'b0;
   endtask

   task automatic write_burst(input int nbeats, input logic [15:0] strb);
      for (int i = 0; i < nbeats; i++) begin
         int n = 0;
         wdata_0 = wbuf[i]; wstrb_0 = strb; wlast_0 = (i == nbeats - 1); wvalid_0 = 1'b1;
         while (wready_0 !== 1'b1 && n < 50) begin @(negedge mem_clk); n++; end
         total++;
         if (wready_0 !== 1'b1) begin
            bad++; $display("FAIL wready_timeout beat=%0d got=%b exp=1", i, wready_0);
         end
         @(negedge mem_clk);
      end
      wvalid_0 = 1'b0; wlast_0 = 1'b0;
   endtask

   task automatic wait_b(input logic [7:0] id);
      int n = 0;
      while (bvalid_0 !== 1'b1 && n < 50) begin @(negedge mem_clk); n++; end
      total++;
      if (bvalid_0 !== 1'b1 || bid_0 !== id) begin
         bad++; $display("FAIL bresp got bvalid=%b bid=%h exp bvalid=1 bid=%h", bvalid_0, bid_0, id);
      end
      bready_0 = 1'b1;
      @(negedge mem_clk);
      bready_0 = 1'b0;
      total++;
      if (aready_0 !== 1'b1) begin
         bad++; $display("FAIL aready_after_b got=%b exp=1", aready_0);
      end
   endtask

   // Drain a read burst, popping one expected word per accepted beat.
   task automatic read_burst(input int nbeats, input logic [7:0] id);
      logic [127:0] exp;
      rready_0 = 1'b1;
      for (int i = 0; i < nbeats; i++) begin
         int n = 0;
         while (rvalid_0 !== 1'b1 && n < 50) begin @(negedge mem_clk); n++; end
         exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
         total++;
         if (rvalid_0 !== 1'b1 || rdata_0 !== exp) begin
            bad++;
            $display("FAIL rdata beat=%0d got=%h exp=%h rvalid=%b", i, rdata_0, exp, rvalid_0);
         end
         total++;
         if (rlast_0 !== (i == nbeats - 1) || rid_0 !== id || rresp_0 !== 2'b00) begin
            bad++;
            $display("FAIL rctl beat=%0d got last=%b id=%h resp=%b exp last=%b id=%h resp=00",
                     i, rlast_0, rid_0, rresp_0, (i == nbeats - 1), id);
         end
         @(negedge mem_clk);
      end
      rready_0 = 1'b0;
      total++;
      if (aready_0 !== 1'b1 || exp_q.size() != 0) begin
         bad++; $display("FAIL read_end got aready=%b left=%0d exp aready=1 left=0",
                         aready_0, exp_q.size());
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (3) @(negedge mem_clk);
      total++;
      if ({aready_0, wready_0, rvalid_0, rlast_0, bvalid_0} !== 5'b10000 ||
          rid_0 !== 8'h00 || bid_0 !== 8'h00 || rdata_0 !== '0 || rresp_0 !== 2'b00) begin
         bad++;
         $display("FAIL reset_values got a=%b w=%b rv=%b rl=%b b=%b rid=%h bid=%h rdata=%h",
                  aready_0, wready_0, rvalid_0, rlast_0, bvalid_0, rid_0, bid_0, rdata_0);
      end
      resetn = 1'b1;
      @(negedge mem_clk);
   endtask

   task automatic test_single();
      wbuf[0] = D1;
      send_cmd(1'b1, 8'h05, 32'h1000, 8'd0, 2'b01);
`ifndef SIM_DDR_LATENCY_EN
      total++;
      if (wready_0 !== 1'b1 || aready_0 !== 1'b0) begin
         bad++; $display("FAIL wready_latency got wready=%b aready=%b exp 1 0", wready_0, aready_0);
      end
`endif
      write_burst(1, 16'hFFFF);
      wait_b(8'h05);
      exp_q.push_back(D1);
      send_cmd(1'b0, 8'h05, 32'h1000, 8'd0, 2'b01);
      read_burst(1, 8'h05);
   endtask

   task automatic test_incr();
      for (int k = 0; k < 4; k++) wbuf[k] = 128'(k);
      send_cmd(1'b1, 8'h11, 32'h2000, 8'd3, 2'b01);
      write_burst(4, 16'hFFFF);
      wait_b(8'h11);
      for (int k = 0; k < 4; k++) exp_q.push_back(128'(k));
      send_cmd(1'b0, 8'h12, 32'h2000, 8'd3, 2'b01);
      read_burst(4, 8'h12);
   endtask

   task automatic test_strobe();
      wbuf[0] = {128{1'b1}};
      send_cmd(1'b1, 8'h21, 32'h2100, 8'd0, 2'b01);
      write_burst(1, 16'hFFFF);
      wait_b(8'h21);
      wbuf[0] = '0;
      send_cmd(1'b1, 8'h22, 32'h2100, 8'd0, 2'b01);
      write_burst(1, 16'h000F);
      wait_b(8'h22);
      exp_q.push_back({{96{1'b1}}, 32'h0});
      send_cmd(1'b0, 8'h23, 32'h2100, 8'd0, 2'b01);
      read_burst(1, 8'h23);
   endtask

   task automatic test_wrap();
      for (int k = 0; k < 4; k++) wbuf[k] = {32'hA5A5_0000 + 32'(k), 96'h0};
      send_cmd(1'b1, 8'h31, 32'h2000, 8'd3, 2'b01);
      write_burst(4, 16'hFFFF);
      wait_b(8'h31);
      exp_q.push_back(wbuf[2]); exp_q.push_back(wbuf[3]);
      exp_q.push_back(wbuf[0]); exp_q.push_back(wbuf[1]);
      send_cmd(1'b0, 8'h32, 32'h2020, 8'd3, 2'b10);
      read_burst(4, 8'h32);
   endtask

   task automatic test_backpressure();
      send_cmd(1'b0, 8'h41, 32'h1000, 8'd0, 2'b01);
      for (int c = 0; c < 5; c++) begin
         total++;
         if (rvalid_0 !== 1'b1 || rdata_0 !== D1 || aready_0 !== 1'b0) begin
            bad++; $display("FAIL r_stall cyc=%0d got rvalid=%b rdata=%h exp 1 %h",
                            c, rvalid_0, rdata_0, D1);
         end
         @(negedge mem_clk);
      end
      exp_q.push_back(D1);
      read_burst(1, 8'h41);
      wbuf[0] = 128'hCAFE;
      send_cmd(1'b1, 8'h42, 32'h4000, 8'd0, 2'b01);
      write_burst(1, 16'hFFFF);
      for (int c = 0; c < 5; c++) begin
         total++;
         if (bvalid_0 !== 1'b1 || aready_0 !== 1'b0) begin
            bad++; $display("FAIL b_stall cyc=%0d got bvalid=%b aready=%b exp 1 0",
                            c, bvalid_0, aready_0);
         end
         @(negedge mem_clk);
      end
      wait_b(8'h42);
   endtask

   task automatic test_reset_mid();
      send_cmd(1'b1, 8'h55, 32'h3000, 8'd7, 2'b01);
      wstrb_0 = 16'hFFFF; wvalid_0 = 1'b1;
      for (int i = 0; i < 2; i++) begin
         wdata_0 = 128'h7700 + 128'(i);
         @(negedge mem_clk);
      end
      wdata_0 = 128'h7702;
      #1 resetn = 1'b0;
      @(posedge mem_clk); #1;
      total++;
      if ({aready_0, wready_0, rvalid_0, rlast_0, bvalid_0} !== 5'b10000 ||
          rid_0 !== 8'h00 || bid_0 !== 8'h00 || rdata_0 !== '0) begin
         bad++; $display("FAIL reset_mid got a=%b w=%b rv=%b rl=%b b=%b rid=%h bid=%h",
                         aready_0, wready_0, rvalid_0, rlast_0, bvalid_0, rid_0, bid_0);
      end
      wvalid_0 = 1'b0;
      @(negedge mem_clk);
      resetn = 1'b1;
      @(negedge mem_clk);
      total++;
      if (aready_0 !== 1'b1) begin
         bad++; $display("FAIL aready_after_reset got=%b exp=1", aready_0);
      end
      exp_q.push_back(128'h7700); exp_q.push_back(128'h7701);
      send_cmd(1'b0, 8'h56, 32'h3000, 8'd1, 2'b01);
      read_burst(2, 8'h56);
   endtask

   initial begin
      @(negedge mem_clk);
      test_reset();
      test_single();
      test_incr();
      test_strobe();
      test_wrap();
      test_backpressure();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
